// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver for the LED-cube host link.
// All pins are resynchronised into clk_in; each completed byte yields a one-cycle strobe.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  input  logic       spi_cs_n_in,
  input  logic       spi_dc_in,
  output logic       byte_rdy_out,
  output logic [7:0] byte_data_out,
  output logic       dc_out
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] dc_sync_r;

  logic       sclk_s;
  logic       mosi_s;
  logic       cs_s;
  logic       dc_s;
  logic       sclk_d_r;
  logic       rise_s;
  logic       take_s;
  logic       complete_s;
  logic       dc_next_s;
  logic       dc_shadow_r;
  logic [7:0] shift_next_s;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_rdy_r;
  logic [7:0] byte_data_r;
  logic       dc_r;

  // Equal-depth synchronisers keep SCK, MOSI, CS_N and DC aligned; CS_N idles deselected.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_sync_r   <= '1;
      dc_sync_r   <= '0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk_in};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi_in};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n_in};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], spi_dc_in};
    end
  end

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign dc_s   = dc_sync_r[SYNC_STAGES-1];
  assign rise_s = sclk_s & ~sclk_d_r;

  // Previous synchronised SCK for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_d_r <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
    end
  end

  // Bit acceptance; a counter still at 7 while CS has just risen lets the last bit complete.
  always_comb begin
    complete_s   = 1'b0;
    take_s       = 1'b0;
    shift_next_s = shift_r;
    dc_next_s    = dc_shadow_r;
    if (rise_s) begin
      complete_s = (bit_cnt_r == 3'd7);
      take_s     = ~cs_s | complete_s;
    end else begin
      complete_s = 1'b0;
      take_s     = 1'b0;
    end
    if (take_s) begin
      if (MSB_FIRST) begin
        shift_next_s = {shift_r[6:0], mosi_s};
      end else begin
        shift_next_s = {mosi_s, shift_r[7:1]};
      end
      dc_next_s = dc_s;
    end else begin
      shift_next_s = shift_r;
      dc_next_s    = dc_shadow_r;
    end
  end

  // Shift register, DC shadow and bit counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_r     <= 8'h00;
      dc_shadow_r <= 1'b0;
      bit_cnt_r   <= 3'd0;
    end else begin
      shift_r     <= shift_next_s;
      dc_shadow_r <= dc_next_s;
      if (cs_s) begin
        bit_cnt_r <= 3'd0;
      end else if (rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Completed byte and DC are captured once and held until the next byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      byte_rdy_r  <= 1'b0;
      byte_data_r <= 8'h00;
      dc_r        <= 1'b0;
    end else begin
      byte_rdy_r <= complete_s;
      if (complete_s) begin
        byte_data_r <= shift_next_s;
        dc_r        <= dc_next_s;
      end else begin
        byte_data_r <= byte_data_r;
        dc_r        <= dc_r;
      end
    end
  end

  assign byte_rdy_out  = byte_rdy_r;
  assign byte_data_out = byte_data_r;
  assign dc_out        = dc_r;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: an MSB-first default instance and an
// LSB-first, three-stage instance share SCK/MOSI/DC but have separate chip selects.
module tb_spi_byte_rx;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       dc = 1'b0;
  logic       cs_a = 1'b1;
  logic       cs_b = 1'b1;
  logic       rdy_a, rdy_b, dcq_a, dcq_b;
  logic [7:0] data_a, data_b;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int consec_a = 0;
  int consec_b = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    int         c;
  } obs_t;

  obs_t obs_a[$];
  obs_t obs_b[$];
  logic [7:0] exp_d[$];
  logic       exp_f[$];
  logic [7:0] last_a;

  spi_byte_rx u_dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .spi_sclk_in(sclk), .spi_mosi_in(mosi), .spi_cs_n_in(cs_a), .spi_dc_in(dc),
    .byte_rdy_out(rdy_a), .byte_data_out(data_a), .dc_out(dcq_a)
  );

  spi_byte_rx #(.SYNC_STAGES(3), .MSB_FIRST(1'b0)) u_dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .spi_sclk_in(sclk), .spi_mosi_in(mosi), .spi_cs_n_in(cs_b), .spi_dc_in(dc),
    .byte_rdy_out(rdy_b), .byte_data_out(data_b), .dc_out(dcq_b)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Strobe recorder: captures every byte event away from the active edge.
  always @(negedge clk_in) begin
    if (rdy_a === 1'b1) obs_a.push_back(obs_t'{d: data_a, f: dcq_a, c: cyc});
    if (rdy_b === 1'b1) obs_b.push_back(obs_t'{d: data_b, f: dcq_b, c: cyc});
    if (rdy_a === 1'b1 && prev_a === 1'b1) consec_a++;
    if (rdy_b === 1'b1 && prev_b === 1'b1) consec_b++;
    prev_a = rdy_a;
    prev_b = rdy_b;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One SPI bit at f_clk/4: two cycles low with data set up, two cycles high.
  task automatic sck_bit(input logic b, input logic d);
    mosi = b;
    dc = d;
    clk_n(2);
    sclk = 1'b1;
    last_rise_cyc = cyc;
    clk_n(2);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d, input bit lsb);
    for (int i = 0; i < 8; i++) sck_bit(lsb ? v[i] : v[7-i], d);
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    clk_n(3);
    n_checks++; if (rdy_a !== 1'b0) $display("FAIL reset_rdy_a: got %b expected 0", rdy_a); else n_pass++;
    n_checks++; if (data_a !== 8'h00) $display("FAIL reset_data_a: got %h expected 00", data_a); else n_pass++;
    n_checks++; if (dcq_a !== 1'b0) $display("FAIL reset_dc_a: got %b expected 0", dcq_a); else n_pass++;
    n_checks++; if (rdy_b !== 1'b0) $display("FAIL reset_rdy_b: got %b expected 0", rdy_b); else n_pass++;
    n_checks++; if (data_b !== 8'h00) $display("FAIL reset_data_b: got %h expected 00", data_b); else n_pass++;
    n_checks++; if (dcq_b !== 1'b0) $display("FAIL reset_dc_b: got %b expected 0", dcq_b); else n_pass++;
    rst_n_in = 1'b1;
    clk_n(4);
  endtask

  task automatic test_single;
    obs_a.delete();
    cs_a = 1'b0;
    clk_n(4);
    send_byte(8'hCC, 1'b0, 1'b0);
    clk_n(8);
    cs_a = 1'b1;
    clk_n(10);
    n_checks++; if (obs_a.size() !== 1) $display("FAIL single_count: got %0d expected 1", obs_a.size()); else n_pass++;
    if (obs_a.size() > 0) begin
      n_checks++; if (obs_a[0].d !== 8'hCC) $display("FAIL single_data: got %h expected cc", obs_a[0].d); else n_pass++;
      n_checks++; if (obs_a[0].f !== 1'b0) $display("FAIL single_dc: got %b expected 0", obs_a[0].f); else n_pass++;
    end
    n_checks++; if (data_a !== 8'hCC) $display("FAIL single_hold_data: got %h expected cc", data_a); else n_pass++;
    n_checks++; if (dcq_a !== 1'b0) $display("FAIL single_hold_dc: got %b expected 0", dcq_a); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    obs_a.delete();
    exp_d.delete();
    exp_f.delete();
    exp_d = '{8'hDA, 8'h12, 8'h34, 8'h56};
    exp_f = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_d.push_back(8'($urandom_range(255, 0)));
      exp_f.push_back(1'($urandom_range(1, 0)));
    end
    cs_a = 1'b0;
    clk_n(4);
    for (int i = 0; i < exp_d.size(); i++) send_byte(exp_d[i], exp_f[i], 1'b0);
    clk_n(8);
    cs_a = 1'b1;
    clk_n(6);
    n_checks++; if (obs_a.size() !== exp_d.size()) $display("FAIL b2b_count: got %0d expected %0d", obs_a.size(), exp_d.size()); else n_pass++;
    n = (obs_a.size() < exp_d.size()) ? obs_a.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      n_checks++; if (obs_a[i].d !== exp_d[i]) $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs_a[i].d, exp_d[i]); else n_pass++;
      n_checks++; if (obs_a[i].f !== exp_f[i]) $display("FAIL b2b_dc[%0d]: got %b expected %b", i, obs_a[i].f, exp_f[i]); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (obs_a[i].c - obs_a[i-1].c < 16) $display("FAIL b2b_spacing[%0d]: got %0d expected >=16", i, obs_a[i].c - obs_a[i-1].c);
        else n_pass++;
      end
    end
    if (n > 0) last_a = exp_d[n-1];
  endtask

  task automatic test_abort;
    obs_a.delete();
    cs_a = 1'b0;
    clk_n(4);
    for (int i = 0; i < 5; i++) sck_bit(1'($urandom_range(1, 0)), 1'b1);
    clk_n(2);
    cs_a = 1'b1;
    clk_n(4);
    cs_a = 1'b0;
    clk_n(4);
    send_byte(8'hA5, 1'b1, 1'b0);
    clk_n(8);
    cs_a = 1'b1;
    clk_n(6);
    n_checks++; if (obs_a.size() !== 1) $display("FAIL abort_count: got %0d expected 1", obs_a.size()); else n_pass++;
    if (obs_a.size() > 0) begin
      n_checks++; if (obs_a[0].d !== 8'hA5) $display("FAIL abort_data: got %h expected a5", obs_a[0].d); else n_pass++;
    end
    last_a = 8'hA5;
  endtask

  task automatic test_deselected;
    obs_a.delete();
    obs_b.delete();
    for (int i = 0; i < 24; i++) sck_bit(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    clk_n(8);
    n_checks++; if (obs_a.size() !== 0) $display("FAIL desel_count_a: got %0d expected 0", obs_a.size()); else n_pass++;
    n_checks++; if (obs_b.size() !== 0) $display("FAIL desel_count_b: got %0d expected 0", obs_b.size()); else n_pass++;
    n_checks++; if (data_a !== last_a) $display("FAIL desel_data: got %h expected %h", data_a, last_a); else n_pass++;
  endtask

  task automatic test_reset_mid;
    obs_a.delete();
    cs_a = 1'b0;
    clk_n(4);
    for (int i = 0; i < 4; i++) sck_bit(1'($urandom_range(1, 0)), 1'b1);
    rst_n_in = 1'b0;
    clk_n(1);
    n_checks++; if (data_a !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", data_a); else n_pass++;
    n_checks++; if (dcq_a !== 1'b0) $display("FAIL rstmid_dc: got %b expected 0", dcq_a); else n_pass++;
    n_checks++; if (rdy_a !== 1'b0) $display("FAIL rstmid_rdy: got %b expected 0", rdy_a); else n_pass++;
    clk_n(2);
    rst_n_in = 1'b1;
    cs_a = 1'b1;
    clk_n(4);
    cs_a = 1'b0;
    clk_n(4);
    send_byte(8'h3C, 1'b0, 1'b0);
    clk_n(8);
    cs_a = 1'b1;
    clk_n(6);
    n_checks++; if (obs_a.size() !== 1) $display("FAIL rstmid_count: got %0d expected 1", obs_a.size()); else n_pass++;
    if (obs_a.size() > 0) begin
      n_checks++; if (obs_a[0].d !== 8'h3C) $display("FAIL rstmid_after: got %h expected 3c", obs_a[0].d); else n_pass++;
    end
  endtask

  task automatic test_lsb_latency;
    int rise8;
    int lat;
    logic [7:0] rnd;
    rnd = 8'($urandom_range(255, 0));
    obs_a.delete();
    obs_b.delete();
    cs_b = 1'b0;
    clk_n(5);
    send_byte(8'h81, 1'b1, 1'b1);
    rise8 = last_rise_cyc;
    send_byte(rnd, 1'b0, 1'b1);
    clk_n(10);
    cs_b = 1'b1;
    clk_n(6);
    n_checks++; if (obs_b.size() !== 2) $display("FAIL lsb_count: got %0d expected 2", obs_b.size()); else n_pass++;
    if (obs_b.size() > 0) begin
      lat = obs_b[0].c - rise8;
      n_checks++; if (obs_b[0].d !== 8'h81) $display("FAIL lsb_data: got %h expected 81", obs_b[0].d); else n_pass++;
      n_checks++; if (obs_b[0].f !== 1'b1) $display("FAIL lsb_dc: got %b expected 1", obs_b[0].f); else n_pass++;
      n_checks++; if (lat < 4 || lat > 6) $display("FAIL lsb_latency: got %0d expected 4..6", lat); else n_pass++;
    end
    if (obs_b.size() > 1) begin
      n_checks++; if (obs_b[1].d !== rnd) $display("FAIL lsb_rand_data: got %h expected %h", obs_b[1].d, rnd); else n_pass++;
    end
    n_checks++; if (obs_a.size() !== 0) $display("FAIL lsb_other_quiet: got %0d expected 0", obs_a.size()); else n_pass++;
  endtask

  task automatic test_strobe_width;
    n_checks++; if (consec_a !== 0) $display("FAIL strobe_width_a: got %0d expected 0", consec_a); else n_pass++;
    n_checks++; if (consec_b !== 0) $display("FAIL strobe_width_b: got %0d expected 0", consec_b); else n_pass++;
  endtask

  initial begin
    last_a = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_deselected();
    test_reset_mid();
    test_lsb_latency();
    test_strobe_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
